sevenseg_scan_driver: RTL and testbench

Multi-digit multiplexed seven-segment display driver. It sits downstream of the BCD counter / digit-generation logic in mojo_top and consumes packed BCD digits. It time-multiplexes the digits onto one shared segment bus with one-hot digit enables. It inserts a dead-time blanking interval between digits to suppress ghosting, and it updates the displayed value atomically at frame boundaries.

---
 rtl/sevenseg_pkg.sv | 28 ++
 rtl/sevenseg_scan_driver_if.sv | 32 +++
 rtl/sevenseg_decode.sv | 28 ++
 rtl/sevenseg_scan_driver.sv | 189 ++++++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
// Shared definitions for the multiplexed seven-segment display path.
//   BCD_W            : width of one packed BCD digit
//   SEG_0..SEG_9     : active-high segment patterns, bit7=a ... bit1=g, bit0=dp
//   SEG_BLANK        : all segments off
//   state_t          : scan FSM states (ST_BLANK dead time, ST_SHOW digit lit)
package sevenseg_pkg;

    localparam int BCD_W = 4;

    localparam logic [7:0] SEG_0     = 8'b1111_1100;
    localparam logic [7:0] SEG_1     = 8'b0110_0000;
    localparam logic [7:0] SEG_2     = 8'b1101_1010;
    localparam logic [7:0] SEG_3     = 8'b1111_0010;
    localparam logic [7:0] SEG_4     = 8'b0110_0110;
    localparam logic [7:0] SEG_5     = 8'b1011_0110;
    localparam logic [7:0] SEG_6     = 8'b1011_1110;
    localparam logic [7:0] SEG_7     = 8'b1110_0000;
    localparam logic [7:0] SEG_8     = 8'b1111_1110;
    localparam logic [7:0] SEG_9     = 8'b1111_0110;
    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// sevenseg_scan_driver_if
// Bundles the digit-load side and the display-pin side of the scan driver.
//   digits_in  : packed BCD, digit 0 in [3:0]
//   dp_in      : decimal-point request per digit
//   load       : one-cycle capture strobe
//   seg        : shared segment bus (a..g, dp)
//   dig_en     : one-hot digit enables
//   frame_done : one-cycle pulse at the start of each new frame
// master = digit generator, slave = scan driver.
interface sevenseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    import sevenseg_pkg::*;

    logic [BCD_W*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]       dp_in;
    logic                        load;
    logic [7:0]                  seg;
    logic [NUM_DIGITS-1:0]       dig_en;
    logic                        frame_done;

    modport master (
        output digits_in, dp_in, load,
        input  seg, dig_en, frame_done
    );

    modport slave (
        input  digits_in, dp_in, load,
        output seg, dig_en, frame_done
    );

endinterface

// File: rtl/sevenseg_decode.sv
// sevenseg_decode
// Combinational BCD to seven-segment decoder (no dp bit).
//   i_bcd  : 4-bit BCD value; 10..15 decode to all segments off
//   o_seg7 : active-high segments, bit6=a ... bit0=g
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [6:0]       o_seg7
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg7 = SEG_0[7:1];
            4'd1:    o_seg7 = SEG_1[7:1];
            4'd2:    o_seg7 = SEG_2[7:1];
            4'd3:    o_seg7 = SEG_3[7:1];
            4'd4:    o_seg7 = SEG_4[7:1];
            4'd5:    o_seg7 = SEG_5[7:1];
            4'd6:    o_seg7 = SEG_6[7:1];
            4'd7:    o_seg7 = SEG_7[7:1];
            4'd8:    o_seg7 = SEG_8[7:1];
            4'd9:    o_seg7 = SEG_9[7:1];
            default: o_seg7 = SEG_BLANK[7:1];
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
// Time-multiplexes NUM_DIGITS BCD digits onto one segment bus with a dead-time
// blank at the start of every slot; new values are latched atomically at frame
// boundaries.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : sevenseg_scan_driver_if.slave (digits_in, dp_in, load -> seg, dig_en, frame_done)
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never).
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 12500,
    parameter int BLANK_CYCLES   = 250,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sevenseg_scan_driver_if.slave bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
    // With no dead time there is no blank phase to start in.
    localparam state_t ST_INIT = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    logic [CNT_W-1:0]            r_cnt;
    logic [IDX_W-1:0]            r_idx;
    state_t                      r_state;
    logic [BCD_W*NUM_DIGITS-1:0] r_active;
    logic [NUM_DIGITS-1:0]       r_active_dp;
    logic [BCD_W*NUM_DIGITS-1:0] r_pend;
    logic [NUM_DIGITS-1:0]       r_pend_dp;
    logic                        r_pend_valid;
    logic [7:0]                  r_seg;
    logic [NUM_DIGITS-1:0]       r_dig;
    logic                        r_bnd_d;
    logic                        r_frame_done;

    logic                        w_wrap;
    logic                        w_boundary;
    logic [CNT_W-1:0]            w_cnt_next;
    state_t                      w_state_next;
    logic [BCD_W-1:0]            w_digit;
    logic                        w_dp;
    logic                        w_blank_sel;
    logic [NUM_DIGITS-1:0]       w_onehot;
    logic [NUM_DIGITS-1:0]       w_lz;
    logic [6:0]                  w_seg7;
    logic [7:0]                  w_seg_next;
    logic [NUM_DIGITS-1:0]       w_dig_next;

    assign w_wrap     = (r_cnt == CNT_LAST);
    assign w_boundary = w_wrap && (r_idx == IDX_LAST);
    assign w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;

    // Slot counter and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_wrap) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state looks at the counter value the state will coincide with,
    // so ST_SHOW holds exactly while r_cnt >= BLANK_CYCLES.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BLANK: if (w_cnt_next == CNT_BLANK) w_state_next = ST_SHOW;
            ST_SHOW:  if (w_wrap && (BLANK_CYCLES != 0)) w_state_next = ST_BLANK;
            default:  w_state_next = ST_INIT;
        endcase
    end

    // Pending/active shadow registers; active only moves at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active     <= '0;
            r_active_dp  <= '0;
            r_pend       <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_boundary) begin
                if (bus.load) begin
                    r_active    <= bus.digits_in;
                    r_active_dp <= bus.dp_in;
                end else if (r_pend_valid) begin
                    r_active    <= r_pend;
                    r_active_dp <= r_pend_dp;
                end
            end
            if (bus.load) begin
                r_pend       <= bus.digits_in;
                r_pend_dp    <= bus.dp_in;
                r_pend_valid <= !w_boundary;
            end else if (w_boundary) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // w_lz[i] set when digit i and all more-significant digits are zero.
    always_comb begin
        logic v_run;
        v_run = 1'b1;
        w_lz  = '0;
        for (int unsigned k = 0; k + 1 < NUM_DIGITS; k++) begin
            v_run = v_run && (r_active[(NUM_DIGITS-1-k)*BCD_W +: BCD_W] == '0);
            w_lz[NUM_DIGITS-1-k] = v_run;
        end
    end
`else
    assign w_lz = '0;
`endif

    // Select the current digit, its dp, blanking flag and one-hot enable
    always_comb begin
        w_digit     = '0;
        w_dp        = 1'b0;
        w_blank_sel = 1'b0;
        w_onehot    = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit     = r_active[i*BCD_W +: BCD_W];
                w_dp        = r_active_dp[i];
                w_blank_sel = w_lz[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    sevenseg_decode u_decode (
        .i_bcd  (w_digit),
        .o_seg7 (w_seg7)
    );

    always_comb begin
        w_seg_next = SEG_BLANK;
        w_dig_next = '0;
        if (r_state == ST_SHOW) begin
            w_seg_next = {(w_blank_sel ? 7'b0 : w_seg7), w_dp};
            w_dig_next = w_onehot;
        end
    end

    // Output register; frame_done is delayed one extra cycle so it lines up
    // with the first output cycle of digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= SEG_INV;
            r_dig        <= DIG_INV;
            r_bnd_d      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_next ^ SEG_INV;
            r_dig        <= w_dig_next ^ DIG_INV;
            r_bnd_d      <= w_boundary;
            r_frame_done <= r_bnd_d;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dig_en     = r_dig;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver
// Self-checking bench: NUM_DIGITS=4, REFRESH_DIV=16, BLANK_CYCLES=2, active-high pins.
// Expectations honour LEADING_ZERO_BLANK_EN when the macro is defined.
module tb_sevenseg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 16;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sevenseg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    sevenseg_scan_driver #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (0),
        .DIG_ACTIVE_LOW (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position p counts clock edges since reset release; the
    // pins after edge p show slot p/RD, offset p%RD. A load seen at edge p takes
    // effect in frame p/FRAME + 1 (last one wins).
    int          p;
    logic [15:0] m_cur, m_next;
    logic [3:0]  m_cur_dp, m_next_dp;

    logic [7:0] segtbl [10];

    typedef struct {
        logic [15:0]     d;
        logic [3:0]      dp;
        bit              at_bnd;
        logic [3:0][7:0] e;     // expected seg, e[3] = digit 3
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (pos %0d)", name, act, exp, p);
        end
    endtask

    function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dpv, input int d);
        logic [3:0] nib;
        logic [7:0] pat;
        logic [15:0] upper;
        upper = v >> (4 * d);
        nib = upper[3:0];
        pat = (nib <= 4'd9) ? segtbl[nib] : 8'h00;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && upper == 16'h0) pat = 8'h00;
`endif
        pat[0] = dpv[d];
        return pat;
    endfunction

    task automatic model_reset();
        p = 0;
        m_cur = '0; m_next = '0; m_cur_dp = '0; m_next_dp = '0;
    endtask

    // One clock: drive inputs, take the edge, compare pins against the model.
    task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] dpv);
        int off, dg;
        logic [7:0] es;
        logic [3:0] ed;
        bus.load = ld; bus.digits_in = d; bus.dp_in = dpv;
        @(posedge clk); #1;
        if (p % FRAME == 0 && p > 0) begin
            m_cur = m_next; m_cur_dp = m_next_dp;
        end
        off = p % RD;
        dg  = (p / RD) % ND;
        if (off < BC) begin
            es = 8'h00; ed = 4'b0000;
        end else begin
            es = exp_seg(m_cur, m_cur_dp, dg);
            ed = 4'b0001 << dg;
        end
        check("seg", {24'h0, bus.seg}, {24'h0, es});
        check("dig_en", {28'h0, bus.dig_en}, {28'h0, ed});
        check("frame_done", {31'h0, bus.frame_done}, {31'h0, (p % FRAME == 0 && p > 0)});
        if (ld) begin
            m_next = d; m_next_dp = dpv;
        end
        p++;
        bus.load = 1'b0;
    endtask

    task automatic idle_until(input int mod_pos);
        while (p % FRAME != mod_pos) step(1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        segtbl = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

        vecs[0] = '{16'h1289, 4'b0000, 1'b0, {8'h60, 8'hDA, 8'hFE, 8'hF6}};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[1] = '{16'h0005, 4'b0001, 1'b1, {8'h00, 8'h00, 8'h00, 8'hB7}};
        vecs[4] = '{16'h0000, 4'b0000, 1'b0, {8'h00, 8'h00, 8'h00, 8'hFC}};
        vecs[6] = '{16'h0040, 4'b0000, 1'b0, {8'h00, 8'h00, 8'h66, 8'hFC}};
`else
        vecs[1] = '{16'h0005, 4'b0001, 1'b1, {8'hFC, 8'hFC, 8'hFC, 8'hB7}};
        vecs[4] = '{16'h0000, 4'b0000, 1'b0, {8'hFC, 8'hFC, 8'hFC, 8'hFC}};
        vecs[6] = '{16'h0040, 4'b0000, 1'b0, {8'hFC, 8'hFC, 8'h66, 8'hFC}};
`endif
        vecs[2] = '{16'hABCD, 4'b0000, 1'b0, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{16'hABCD, 4'b1111, 1'b0, {8'h01, 8'h01, 8'h01, 8'h01}};
        vecs[5] = '{16'h7364, 4'b1010, 1'b1, {8'hE1, 8'hF2, 8'hBF, 8'h66}};

        bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0;
        model_reset();

        // Reset hold
        repeat (3) begin
            @(negedge clk);
            check("rst_seg", {24'h0, bus.seg}, 32'h0);
            check("rst_dig_en", {28'h0, bus.dig_en}, 32'h0);
            check("rst_frame_done", {31'h0, bus.frame_done}, 32'h0);
        end
        rst_n = 1'b1;

        // Two idle frames: digits read 0 everywhere, frame_done every FRAME cycles
        repeat (2 * FRAME) step(1'b0, 16'h0, 4'h0);

        // Table vectors: load mid-frame (digit 1) or on the boundary cycle,
        // then inspect every digit of the following frame.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].at_bnd) idle_until(FRAME - 1);
            else                idle_until(RD + 4);
            step(1'b1, vecs[i].d, vecs[i].dp);
            idle_until(0);
            for (int d = 0; d < ND; d++) begin
                idle_until(d * RD + 6);
                check("vec_seg", {24'h0, bus.seg}, {24'h0, vecs[i].e[d]});
                check("vec_dig_en", {28'h0, bus.dig_en}, 32'h1 << d);
            end
        end

        // Several loads within one frame: only the last should appear
        idle_until(3);
        step(1'b1, 16'h1111, 4'h0);
        idle_until(30);
        step(1'b1, 16'h2222, 4'h0);
        idle_until(50);
        step(1'b1, 16'h3456, 4'h4);
        idle_until(RD + 6);
        check("lastwins_d1", {24'h0, bus.seg}, {24'h0, 8'hB6});
        idle_until(2 * RD + 6);
        check("lastwins_d2", {24'h0, bus.seg}, {24'h0, 8'h67});

        // Asynchronous reset in the middle of digit 2's SHOW phase
        step(1'b1, 16'h8888, 4'hF);
        idle_until(0);
        idle_until(2 * RD + 8);
        check("pre_rst_dig_en", {28'h0, bus.dig_en}, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg", {24'h0, bus.seg}, 32'h0);
        check("async_rst_dig_en", {28'h0, bus.dig_en}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (FRAME + 8) step(1'b0, 16'h0, 4'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 29) == 0)
                step(1'b1, 16'($urandom), 4'($urandom));
            else
                step(1'b0, 16'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
